gpio_io_controller: RTL and testbench
=====================================

Name: gpio_io_controller

Overview:
- CPU-side I/O-space bus master for the GPIO register banks. It is the initiator end of the DDRx/PORTx/PINx register interface.
- Executes AVR I/O operations (IN, OUT, SBI, CBI, SBIS, SBIC) from the instruction decoder against ports A–D.
- SBI, CBI, SBIS and SBIC run as a multi-cycle read-modify-write or read-test sequence.
- Drives the per-port write enables and write data. Reads back DDRx/PORTx/PINx through an internal select mux.

Parameters:
- NUM_PORTS, 4, number of GPIO banks (A..D); bank n occupies bits [8n+7:8n] of the packed buses.
- WIDTH, 8, register width per bank.

Ports:
- clk  input  1  system clock.
- clr  input  1  synchronous active-high reset.
- req  input  1  operation request; sampled only while ready=1.
- op  input  3  0 NOP, 1 IN, 2 OUT, 3 SBI, 4 CBI, 5 SBIS, 6 SBIC, 7 reserved.
- io_addr  input  6  AVR I/O address.
- bit_sel  input  3  bit index for SBI/CBI/SBIS/SBIC.
- wdata  input  WIDTH  OUT data.
- ready  output  1  idle, can accept req.
- done  output  1  one-cycle completion pulse.
- rdata  output  WIDTH  IN result; held until next accepted req.
- skip  output  1  SBIS/SBIC skip result, valid with done.
- err  output  1  pulses with done on a bad address or a write to PINx.
- ddr_we  output  NUM_PORTS  per-bank DDRx write enable.
- port_we  output  NUM_PORTS  per-bank PORTx write enable.
- gpio_wdata  output  WIDTH  shared write data to all banks.
- ddr_in  input  NUM_PORTS*WIDTH  packed DDRx outputs.
- port_in  input  NUM_PORTS*WIDTH  packed PORTx outputs.
- pin_in  input  NUM_PORTS*WIDTH  packed PINx outputs.
- verify_fail  output  1  see Optional Feature.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset clr is synchronous, active-high.
  - On a clr edge: state=IDLE; ready=1; done=0; skip=0; err=0; rdata=0; gpio_wdata=0; all we=0; verify_fail=0.
  - clr during any operation aborts it; no write enable is asserted after that edge.
- Address map (bank index: PIN/DDR/PORT):
  - A=0: 0x19/0x1A/0x1B
  - B=1: 0x16/0x17/0x18
  - C=2: 0x13/0x14/0x15
  - D=3: 0x10/0x11/0x12
  - Any other address is invalid.
- States: IDLE, READ, WRITE, DONE (plus VERIFY with the macro).
- IDLE:
  - ready=1.
  - req=1 latches op, io_addr, bit_sel and wdata, and clears rdata/skip/err. This is cycle 0.
  - req with op=NOP completes immediately: DONE at cycle 1, no error.
- Transitions (DONE is the cycle where done=1):
  - IN: IDLE→READ (selected register captured into rdata at end of READ)→DONE. done at cycle 2.
  - OUT: IDLE→WRITE→DONE.
    - In WRITE, the selected we is high for exactly one cycle and gpio_wdata=wdata.
    - done at cycle 2.
  - SBI/CBI: IDLE→READ→WRITE→DONE.
    - WRITE drives the captured value with bit_sel set (SBI) or cleared (CBI).
    - done at cycle 3.
  - SBIS/SBIC: IDLE→READ→DONE. skip = selected bit ==1 (SBIS) or ==0 (SBIC). done at cycle 2.
  - DONE→IDLE unconditionally. ready=0 in every state other than IDLE.
- Errors and unsupported targets:
  - Invalid address, or reserved op 7: IDLE→DONE with err=1; no we asserted.
  - OUT/SBI/CBI to a PIN address: err=1, no we, done at the normal latency for that op.
  - IN/SBIS/SBIC to PIN is legal.
- Write enables:
  - At most one we bit is asserted in any cycle.
  - we is only high in WRITE.
- Register reads:
  - Sampled from the bus during READ only. Changes on the bus outside READ are ignored.
  - PORTx writes are masked by DDRx in the bank. The controller writes unmasked data and does not compensate.
- Back-to-back: req held high is re-accepted on the IDLE cycle following DONE.

Optional Feature:
- Macro: GPIO_CTRL_WRITE_VERIFY_EN.
- Enabled:
  - After WRITE, the FSM enters VERIFY, which adds 1 cycle of latency.
  - VERIFY reads back the written register and compares it to the expected value:
    - DDR target: the value written.
    - PORT target: value written & ddr_in of that bank.
  - On mismatch, verify_fail=1 for the DONE cycle.
- Disabled: no VERIFY state; verify_fail is tied 0.

Test Plan:
- Reset: clr=1 for 2 cycles mid-SBI → next cycle ready=1, all we=0, rdata=0x00; no write occurs.
- OUT 0xA5 to 0x17 (DDRB): ddr_we=4'b0010 for one cycle with gpio_wdata=0xA5; done at cycle 2. Then IN 0x17 → rdata=0xA5.
- DDRB=0x0F, PORTB=0x00, SBI 0x18 bit 2: READ captures 0x00, WRITE drives 0x04 on port_we[1]; done at cycle 3; PORTB=0x04. Then CBI bit 2 → PORTB=0x00.
- PIND=0x80: SBIS 0x10 bit 7 → skip=1. SBIC 0x10 bit 7 → skip=0. Both done at cycle 2.
- OUT to 0x19 (PINA) and IN from 0x3F: err=1 with done; no we in either case.
- Macro enabled, DDRA=0x0F, OUT 0xFF to 0x1B: expected value 0x0F; PORTA=0x0F, so verify_fail=0; done at cycle 3. Force a bus mismatch → verify_fail=1.

Source files
------------

// File: rtl/gpio_io_controller.sv
// I/O-space bus master executing AVR IN/OUT/SBI/CBI/SBIS/SBIC against GPIO banks A..D.
// Define GPIO_CTRL_WRITE_VERIFY_EN to add a post-write read-back check (VERIFY state).
module gpio_io_controller #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       req,
    input  logic [2:0]                 op,
    input  logic [5:0]                 io_addr,
    input  logic [2:0]                 bit_sel,
    input  logic [WIDTH-1:0]           wdata,
    output logic                       ready,
    output logic                       done,
    output logic [WIDTH-1:0]           rdata,
    output logic                       skip,
    output logic                       err,
    output logic [NUM_PORTS-1:0]       ddr_we,
    output logic [NUM_PORTS-1:0]       port_we,
    output logic [WIDTH-1:0]           gpio_wdata,
    input  logic [NUM_PORTS*WIDTH-1:0] ddr_in,
    input  logic [NUM_PORTS*WIDTH-1:0] port_in,
    input  logic [NUM_PORTS*WIDTH-1:0] pin_in,
    output logic                       verify_fail
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_IN   = 3'd1;
    localparam logic [2:0] OP_OUT  = 3'd2;
    localparam logic [2:0] OP_SBI  = 3'd3;
    localparam logic [2:0] OP_SBIS = 3'd5;
    localparam logic [2:0] OP_SBIC = 3'd6;
    localparam logic [2:0] OP_RSV  = 3'd7;

`ifdef GPIO_CTRL_WRITE_VERIFY_EN
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_DONE, S_VERIFY} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
`endif

    typedef enum logic [1:0] {K_PIN, K_DDR, K_PORT, K_NONE} kind_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [5:0]       addr_q;
    logic [2:0]       bit_q;
    logic [5:0]       dec_addr;
    logic [1:0]       bank;
    kind_t            kind;
    logic [WIDTH-1:0] sel_val;
    logic [WIDTH-1:0] bit_mask;
    logic [NUM_PORTS-1:0] we_vec;

    // While idle decode the incoming address; afterwards the latched one.
    always_comb begin
        dec_addr = (state == S_IDLE) ? io_addr : addr_q;
        bank     = 2'd0;
        kind     = K_NONE;
        case (dec_addr)
            6'h19: begin bank = 2'd0; kind = K_PIN;  end
            6'h1A: begin bank = 2'd0; kind = K_DDR;  end
            6'h1B: begin bank = 2'd0; kind = K_PORT; end
            6'h16: begin bank = 2'd1; kind = K_PIN;  end
            6'h17: begin bank = 2'd1; kind = K_DDR;  end
            6'h18: begin bank = 2'd1; kind = K_PORT; end
            6'h13: begin bank = 2'd2; kind = K_PIN;  end
            6'h14: begin bank = 2'd2; kind = K_DDR;  end
            6'h15: begin bank = 2'd2; kind = K_PORT; end
            6'h10: begin bank = 2'd3; kind = K_PIN;  end
            6'h11: begin bank = 2'd3; kind = K_DDR;  end
            6'h12: begin bank = 2'd3; kind = K_PORT; end
            default: ;
        endcase
    end

    always_comb begin
        sel_val = '0;
        case (kind)
            K_PIN:   sel_val = pin_in[int'(bank)*WIDTH +: WIDTH];
            K_DDR:   sel_val = ddr_in[int'(bank)*WIDTH +: WIDTH];
            K_PORT:  sel_val = port_in[int'(bank)*WIDTH +: WIDTH];
            default: ;
        endcase
        bit_mask = WIDTH'(1) << bit_q;
        we_vec   = NUM_PORTS'(1) << bank;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= S_IDLE;
            ready      <= 1'b1;
            done       <= 1'b0;
            skip       <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
            gpio_wdata <= '0;
            ddr_we     <= '0;
            port_we    <= '0;
            op_q       <= OP_NOP;
            addr_q     <= '0;
            bit_q      <= '0;
`ifdef GPIO_CTRL_WRITE_VERIFY_EN
            verify_fail <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        op_q       <= op;
                        addr_q     <= io_addr;
                        bit_q      <= bit_sel;
                        gpio_wdata <= wdata;
                        rdata      <= '0;
                        skip       <= 1'b0;
                        err        <= 1'b0;
                        ready      <= 1'b0;
                        if (op == OP_NOP) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (op == OP_RSV || kind == K_NONE) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (op == OP_OUT) begin
                            // A PIN target walks the normal path with no enable, flagged at done
                            state <= S_WRITE;
                            if (kind == K_DDR)  ddr_we  <= we_vec;
                            if (kind == K_PORT) port_we <= we_vec;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    case (op_q)
                        OP_IN: begin
                            rdata <= sel_val;
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                        OP_SBIS, OP_SBIC: begin
                            skip  <= (op_q == OP_SBIS) ? sel_val[bit_q] : !sel_val[bit_q];
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                        default: begin
                            gpio_wdata <= (op_q == OP_SBI) ? (sel_val | bit_mask) : (sel_val & ~bit_mask);
                            state      <= S_WRITE;
                            if (kind == K_DDR)  ddr_we  <= we_vec;
                            if (kind == K_PORT) port_we <= we_vec;
                        end
                    endcase
                end
                S_WRITE: begin
                    ddr_we  <= '0;
                    port_we <= '0;
`ifdef GPIO_CTRL_WRITE_VERIFY_EN
                    state   <= S_VERIFY;
`else
                    state   <= S_DONE;
                    done    <= 1'b1;
                    err     <= (kind == K_PIN);
`endif
                end
`ifdef GPIO_CTRL_WRITE_VERIFY_EN
                // Bank registers now hold the write; PORT reads back masked by DDR
                S_VERIFY: begin
                    state       <= S_DONE;
                    done        <= 1'b1;
                    err         <= (kind == K_PIN);
                    verify_fail <= (kind != K_PIN) &&
                                   (sel_val != ((kind == K_PORT) ?
                                    (gpio_wdata & ddr_in[int'(bank)*WIDTH +: WIDTH]) : gpio_wdata));
                end
`endif
                S_DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
`ifdef GPIO_CTRL_WRITE_VERIFY_EN
                    verify_fail <= 1'b0;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef GPIO_CTRL_WRITE_VERIFY_EN
    assign verify_fail = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_io_controller.sv
// Directed bench for gpio_io_controller with a behavioural model of four GPIO banks.
module tb_gpio_io_controller;

    localparam int unsigned NP = 4;
    localparam int unsigned W  = 8;
`ifdef GPIO_CTRL_WRITE_VERIFY_EN
    localparam int WL = 1;
`else
    localparam int WL = 0;
`endif

    logic            clk = 1'b0;
    logic            clr;
    logic            req;
    logic [2:0]      op;
    logic [5:0]      io_addr;
    logic [2:0]      bit_sel;
    logic [W-1:0]    wdata;
    logic            ready, done, skip, err, verify_fail;
    logic [W-1:0]    rdata, gpio_wdata;
    logic [NP-1:0]   ddr_we, port_we;
    logic [NP*W-1:0] ddr_bus, port_bus, pin_bus;

    logic [W-1:0] ddr_m [NP];
    logic [W-1:0] port_m[NP];
    logic [W-1:0] pin_m [NP];
    logic         bus_rst;
    logic [W-1:0] corrupt;

    int tests = 0;
    int fails = 0;
    int we_cnt = 0;
    logic          we_multi = 1'b0;
    logic [NP-1:0] last_ddr_we = '0;
    logic [NP-1:0] last_port_we = '0;
    logic [W-1:0]  last_wd = '0;

    int           lat;
    logic         o_err, o_skip, o_vf;
    int           we_base;

    always #5 clk = ~clk;

    assign ddr_bus  = {ddr_m[3], ddr_m[2], ddr_m[1], ddr_m[0]};
    assign port_bus = {port_m[3], port_m[2], port_m[1], port_m[0] ^ corrupt};
    assign pin_bus  = {pin_m[3], pin_m[2], pin_m[1], pin_m[0]};

    gpio_io_controller #(.NUM_PORTS(NP), .WIDTH(W)) dut (
        .clk(clk), .clr(clr), .req(req), .op(op), .io_addr(io_addr),
        .bit_sel(bit_sel), .wdata(wdata), .ready(ready), .done(done),
        .rdata(rdata), .skip(skip), .err(err), .ddr_we(ddr_we),
        .port_we(port_we), .gpio_wdata(gpio_wdata), .ddr_in(ddr_bus),
        .port_in(port_bus), .pin_in(pin_bus), .verify_fail(verify_fail)
    );

    // Bank registers; PORT writes are masked by the bank's DDR.
    always @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (bus_rst) begin
                ddr_m[i]  <= '0;
                port_m[i] <= '0;
            end else begin
                if (ddr_we[i])  ddr_m[i]  <= gpio_wdata;
                if (port_we[i]) port_m[i] <= gpio_wdata & ddr_m[i];
            end
        end
    end

    always @(negedge clk) begin
        if (|ddr_we || |port_we) begin
            we_cnt++;
            last_ddr_we  = ddr_we;
            last_port_we = port_we;
            last_wd      = gpio_wdata;
            if ($countones({ddr_we, port_we}) > 1) we_multi = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [5:0] a, input logic [2:0] b,
                          input logic [W-1:0] d);
        @(negedge clk);
        req = 1'b1; op = o; io_addr = a; bit_sel = b; wdata = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        lat = 1;
        while (!done && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            tests++;
            fails++;
            $error("FAIL timeout waiting for done op=%0d addr=0x%0h", o, a);
        end
        o_err = err; o_skip = skip; o_vf = verify_fail;
    endtask

    initial begin
        clr = 1'b1; req = 1'b0; op = 3'd0; io_addr = '0; bit_sel = '0; wdata = '0;
        bus_rst = 1'b1; corrupt = '0;
        for (int i = 0; i < NP; i++) pin_m[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0; bus_rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'h00);
        chk("rst_err_skip", 32'({err, skip, verify_fail}), 32'd0);
        chk("rst_we", 32'({ddr_we, port_we}), 32'd0);
        chk("rst_gpio_wdata", 32'(gpio_wdata), 32'h00);

        // OUT 0xA5 to DDRB then IN
        we_base = we_cnt;
        run_op(3'd2, 6'h17, 3'd0, 8'hA5);
        chk("out_ddrb_lat", 32'(lat), 32'(2 + WL));
        chk("out_ddrb_we_count", 32'(we_cnt - we_base), 32'd1);
        chk("out_ddrb_ddr_we", 32'(last_ddr_we), 32'b0010);
        chk("out_ddrb_port_we", 32'(last_port_we), 32'b0000);
        chk("out_ddrb_wdata", 32'(last_wd), 32'hA5);
        chk("out_ddrb_err_vf", 32'({o_err, o_vf}), 32'd0);
        run_op(3'd1, 6'h17, 3'd0, 8'h00);
        chk("in_ddrb_lat", 32'(lat), 32'd2);
        chk("in_ddrb_rdata", 32'(rdata), 32'hA5);

        // DDRB=0x0F, SBI/CBI PORTB bit 2
        run_op(3'd2, 6'h17, 3'd0, 8'h0F);
        we_base = we_cnt;
        run_op(3'd3, 6'h18, 3'd2, 8'h00);
        chk("sbi_lat", 32'(lat), 32'(3 + WL));
        chk("sbi_port_we", 32'(last_port_we), 32'b0010);
        chk("sbi_wdata", 32'(last_wd), 32'h04);
        chk("sbi_we_count", 32'(we_cnt - we_base), 32'd1);
        run_op(3'd1, 6'h18, 3'd0, 8'h00);
        chk("sbi_portb_readback", 32'(rdata), 32'h04);
        run_op(3'd4, 6'h18, 3'd2, 8'h00);
        chk("cbi_lat", 32'(lat), 32'(3 + WL));
        chk("cbi_wdata", 32'(last_wd), 32'h00);
        run_op(3'd1, 6'h18, 3'd0, 8'h00);
        chk("cbi_portb_readback", 32'(rdata), 32'h00);

        // SBIS/SBIC on PIND
        pin_m[3] = 8'h80;
        run_op(3'd5, 6'h10, 3'd7, 8'h00);
        chk("sbis_lat", 32'(lat), 32'd2);
        chk("sbis_skip", 32'(o_skip), 32'd1);
        run_op(3'd6, 6'h10, 3'd7, 8'h00);
        chk("sbic_lat", 32'(lat), 32'd2);
        chk("sbic_skip", 32'(o_skip), 32'd0);
        run_op(3'd6, 6'h10, 3'd0, 8'h00);
        chk("sbic_bit0_skip", 32'(o_skip), 32'd1);

        // Errors: write to PIN, invalid address, reserved op; NOP
        we_base = we_cnt;
        run_op(3'd2, 6'h19, 3'd0, 8'hFF);
        chk("out_pin_lat", 32'(lat), 32'(2 + WL));
        chk("out_pin_err", 32'(o_err), 32'd1);
        run_op(3'd1, 6'h3F, 3'd0, 8'h00);
        chk("in_bad_lat", 32'(lat), 32'd1);
        chk("in_bad_err", 32'(o_err), 32'd1);
        run_op(3'd3, 6'h13, 3'd1, 8'h00);
        chk("sbi_pin_lat", 32'(lat), 32'(3 + WL));
        chk("sbi_pin_err", 32'(o_err), 32'd1);
        run_op(3'd7, 6'h17, 3'd0, 8'h00);
        chk("rsv_op_err", 32'({lat[3:0], o_err}), 32'({4'd1, 1'b1}));
        chk("err_no_we", 32'(we_cnt - we_base), 32'd0);
        run_op(3'd0, 6'h3F, 3'd0, 8'h00);
        chk("nop_lat_err", 32'({lat[3:0], o_err}), 32'({4'd1, 1'b0}));

        // clr held two cycles mid-SBI aborts without a write
        run_op(3'd1, 6'h17, 3'd0, 8'h00);
        chk("pre_abort_rdata", 32'(rdata), 32'h0F);
        we_base = we_cnt;
        @(negedge clk);
        req = 1'b1; op = 3'd3; io_addr = 6'h18; bit_sel = 3'd3;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_rdata", 32'(rdata), 32'h00);
        chk("abort_we_now", 32'({ddr_we, port_we}), 32'd0);
        chk("abort_no_write", 32'(we_cnt - we_base), 32'd0);
        run_op(3'd1, 6'h18, 3'd0, 8'h00);
        chk("abort_portb_unchanged", 32'(rdata), 32'h00);

        // DDRA=0x0F then OUT 0xFF to PORTA: read-back equals masked value
        run_op(3'd2, 6'h1A, 3'd0, 8'h0F);
        run_op(3'd2, 6'h1B, 3'd0, 8'hFF);
        chk("outa_lat", 32'(lat), 32'(2 + WL));
        chk("outa_vf", 32'(o_vf), 32'd0);
        run_op(3'd1, 6'h1B, 3'd0, 8'h00);
        chk("outa_porta", 32'(rdata), 32'h0F);
        corrupt = 8'h01;
        run_op(3'd2, 6'h1B, 3'd0, 8'hFF);
        chk("outa_corrupt_vf", 32'(o_vf), 32'(WL));
        corrupt = 8'h00;

        chk("we_onehot", 32'(we_multi), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
